// File: rtl/mem_scan_ram.sv
// mem_scan_ram: writable memory stage that feeds the downstream display lookup.
// Writes from the switches commit on a wr_en rising edge, one write per press.
// Reads come either from the rd_addr switches (MANUAL mode) or from an internal
// pointer that advances every SCAN_DIV clocks (SCAN mode). The read is registered,
// so addr_out/data_out appear one cycle after the address is presented.
//
// Ports:
//   clk_2     in   single clock, rising edge
//   reset     in   asynchronous, active-high reset
//   rd_addr   in   MANUAL-mode read address
//   wr_addr   in   write address
//   wr_data   in   write data
//   wr_en     in   write request level, acted on at its rising edge
//   scan_en   in   1 = SCAN, 0 = MANUAL
//   addr_out  out  registered address of the word on data_out
//   data_out  out  registered read data
//   wr_pulse  out  one-cycle strobe on the cycle a write commits
//   scanning  out  high while the FSM is in SCAN
module mem_scan_ram #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SCAN_DIV   = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  scan_en,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_pulse,
    output logic                  scanning
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_cnt_nxt;
    logic                  wr_en_q;
    logic                  commit_c;
    logic [ADDR_WIDTH-1:0] cur_c;

    // Power-on contents; entries beyond the first four clear to zero.
    function automatic logic [DATA_WIDTH-1:0] reset_word(input int unsigned idx);
        case (idx)
            32'd0:   reset_word = DATA_WIDTH'(4'b0110);
            32'd1:   reset_word = DATA_WIDTH'(4'b1100);
            32'd2:   reset_word = DATA_WIDTH'(4'b1001);
            32'd3:   reset_word = DATA_WIDTH'(4'b0101);
            default: reset_word = '0;
        endcase
    endfunction

    // Rising-edge detect; wr_en_q resets high so a held switch never writes on release.
    assign commit_c = wr_en & ~wr_en_q;

    // State register.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state <= ST_MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_MANUAL: if (scan_en)  state_nxt = ST_SCAN;
            ST_SCAN:   if (!scan_en) state_nxt = ST_MANUAL;
            default:   state_nxt = ST_MANUAL;
        endcase
    end

    // Output/datapath logic: read address select and scan stepping.
    always_comb begin
        ptr_nxt     = ptr;
        div_cnt_nxt = div_cnt;
        cur_c       = rd_addr;
        if (state == ST_SCAN) begin
            cur_c = ptr;
            if (div_cnt == DIV_LAST) begin
                div_cnt_nxt = '0;
                ptr_nxt     = ptr + ADDR_WIDTH'(1);
            end else begin
                div_cnt_nxt = div_cnt + DIV_W'(1);
            end
        end
        // A fresh scan entry always starts a full dwell on the held pointer.
        if ((state == ST_MANUAL) && (state_nxt == ST_SCAN)) begin
            div_cnt_nxt = '0;
        end
    end

    // Registered datapath, memory and outputs. Read uses the pre-write word (read-old).
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= reset_word(i);
            end
            ptr      <= '0;
            div_cnt  <= '0;
            wr_en_q  <= 1'b1;
            addr_out <= '0;
            data_out <= '0;
            wr_pulse <= 1'b0;
            scanning <= 1'b0;
        end else begin
            if (commit_c) begin
                mem[wr_addr] <= wr_data;
            end
            ptr      <= ptr_nxt;
            div_cnt  <= div_cnt_nxt;
            wr_en_q  <= wr_en;
            addr_out <= cur_c;
            data_out <= mem[cur_c];
            wr_pulse <= commit_c;
            scanning <= (state_nxt == ST_SCAN);
        end
    end

endmodule
